// File: rtl/soc_uart_wb_pkg.sv
// Shared constants for the SoC UART Wishbone target port.
// Contents: local address width, register indices (adr[4:2]) and byte offsets,
// and bit positions inside the STATUS and IER registers.
package soc_uart_wb_pkg;

  localparam int unsigned LOCAL_AW = 24;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BYTE_W   = 8;

  // Register index as decoded from adr[4:2]
  localparam logic [2:0] REG_TXDATA = 3'd0;
  localparam logic [2:0] REG_RXDATA = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_IER    = 3'd3;

  // Byte offsets of the same registers
  localparam logic [LOCAL_AW-1:0] OFS_TXDATA = 24'h00_0000;
  localparam logic [LOCAL_AW-1:0] OFS_RXDATA = 24'h00_0004;
  localparam logic [LOCAL_AW-1:0] OFS_STATUS = 24'h00_0008;
  localparam logic [LOCAL_AW-1:0] OFS_IER    = 24'h00_000C;

  // STATUS bit positions
  localparam int unsigned ST_TX_EMPTY = 0;
  localparam int unsigned ST_TX_FULL  = 1;
  localparam int unsigned ST_RX_VALID = 2;
  localparam int unsigned ST_TX_OVF   = 3;
  localparam int unsigned ST_RX_OVF   = 4;
  localparam int unsigned ST_CNT_LSB  = 8;
  localparam int unsigned ST_CNT_W    = 8;

  // IER bit positions
  localparam int unsigned IER_RX_IE  = 0;
  localparam int unsigned IER_TXE_IE = 1;

endpackage : soc_uart_wb_pkg

// File: rtl/soc_uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmit path.
// Ports: i_clk/i_rst (sync, active-high), i_push/i_data write side,
// i_pop read side, o_data head entry (0 while empty), o_full, o_empty,
// o_count occupancy (AW+1 bits).
// A push while full or a pop while empty is ignored; full/empty use the
// pre-edge count, so a push on a full FIFO is dropped even with a pop.
module soc_uart_tx_fifo #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CNT_W = AW + 1;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // Storage array, not reset
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally at DEPTH
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : soc_uart_tx_fifo

// File: rtl/soc_uart_wb_slave.sv
// Wishbone slave for the SoC UART target: TX byte FIFO drained over a
// valid/ready stream, one-byte RX holding register, sticky overflow flags
// and a registered level interrupt.
// Ports: wb_* Wishbone slave (24-bit byte address, 32-bit data, ack/err),
// int_o level interrupt, tx_data_o/tx_valid_o/tx_ready_i TX stream,
// rx_data_i/rx_valid_i/rx_ready_o RX stream (never back-pressured).
// Every request is answered by exactly one ack or err in the next cycle.
module soc_uart_wb_slave
  import soc_uart_wb_pkg::*;
#(
  parameter int unsigned TX_FIFO_AW = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [LOCAL_AW-1:0] wb_adr_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                int_o,
  output logic [BYTE_W-1:0]   tx_data_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  input  logic [BYTE_W-1:0]   rx_data_i,
  input  logic                rx_valid_i,
  output logic                rx_ready_o
);

  localparam int unsigned CNT_W = TX_FIFO_AW + 1;

  logic              r_ack;
  logic              r_err;
  logic [DATA_W-1:0] r_dat;
  logic              r_int;
  logic              r_rx_ready;
  logic              r_rx_valid;
  logic [BYTE_W-1:0] r_rx_byte;
  logic              r_tx_ovf;
  logic              r_rx_ovf;
  logic              r_rx_ie;
  logic              r_txe_ie;

  logic              w_req;
  logic [2:0]        w_idx;
  logic              w_adr_ok;
  logic              w_rd;
  logic              w_wr;
  logic              w_tx_push;
  logic              w_tx_pop;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic [CNT_W-1:0]  w_tx_count;
  logic              w_rx_pop;
  logic              w_rx_ovf_set;
  logic              w_status_wr;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_unused;

  // Request qualification and address decode
  assign w_req    = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
  assign w_idx    = wb_adr_i[4:2];
  assign w_adr_ok = (wb_adr_i[LOCAL_AW-1:5] == '0) && (w_idx <= REG_IER);
  assign w_rd     = w_req & w_adr_ok & ~wb_we_i;
  assign w_wr     = w_req & w_adr_ok & wb_we_i & wb_sel_i[0];

  assign w_tx_push    = w_wr && (w_idx == REG_TXDATA);
  assign w_tx_pop     = ~w_tx_empty & tx_ready_i;
  assign w_rx_pop     = w_rd && (w_idx == REG_RXDATA) && r_rx_valid;
  assign w_status_wr  = w_wr && (w_idx == REG_STATUS);
  // A new byte that finds the holder occupied (and not being read) is lost
  assign w_rx_ovf_set = rx_valid_i & r_rx_valid & ~w_rx_pop;

  // Address bits [1:0], upper data bits and lanes 1..3 carry no function
  assign w_unused = ^{wb_adr_i[1:0], wb_dat_i[DATA_W-1:BYTE_W], wb_sel_i[3:1]};

  soc_uart_tx_fifo #(
    .AW (TX_FIFO_AW),
    .DW (BYTE_W)
  ) u_tx_fifo (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_push  (w_tx_push),
    .i_data  (wb_dat_i[BYTE_W-1:0]),
    .i_pop   (w_tx_pop),
    .o_data  (tx_data_o),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  // STATUS image from pre-edge state
  always_comb begin
    w_status              = '0;
    w_status[ST_TX_EMPTY] = w_tx_empty;
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_RX_VALID] = r_rx_valid;
    w_status[ST_TX_OVF]   = r_tx_ovf;
    w_status[ST_RX_OVF]   = r_rx_ovf;
    w_status[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(w_tx_count);
  end

  // Read data mux
  always_comb begin
    w_rd_data = '0;
    case (w_idx)
      REG_RXDATA: w_rd_data = DATA_W'({r_rx_valid, r_rx_byte});
      REG_STATUS: w_rd_data = w_status;
      REG_IER: begin
        w_rd_data[IER_RX_IE]  = r_rx_ie;
        w_rd_data[IER_TXE_IE] = r_txe_ie;
      end
      default: w_rd_data = '0;
    endcase
  end

  // Bus response: one-cycle ack or err, data only on acked reads
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req & w_adr_ok;
      r_err <= w_req & ~w_adr_ok;
      r_dat <= w_rd ? w_rd_data : '0;
    end
  end

  // Control registers and sticky flags; a flag set beats a same-cycle clear
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_tx_ovf   <= 1'b0;
      r_rx_ovf   <= 1'b0;
      r_rx_ie    <= 1'b0;
      r_txe_ie   <= 1'b0;
      r_rx_ready <= 1'b0;
      r_int      <= 1'b0;
    end else begin
      r_rx_ready <= 1'b1;
      if (w_tx_push && w_tx_full) begin
        r_tx_ovf <= 1'b1;
      end else if (w_status_wr && wb_dat_i[ST_TX_OVF]) begin
        r_tx_ovf <= 1'b0;
      end
      if (w_rx_ovf_set) begin
        r_rx_ovf <= 1'b1;
      end else if (w_status_wr && wb_dat_i[ST_RX_OVF]) begin
        r_rx_ovf <= 1'b0;
      end
      if (w_wr && (w_idx == REG_IER)) begin
        r_rx_ie  <= wb_dat_i[IER_RX_IE];
        r_txe_ie <= wb_dat_i[IER_TXE_IE];
      end
      r_int <= (r_rx_ie & r_rx_valid) | (r_txe_ie & w_tx_empty);
    end
  end

  // RX holding register; a same-edge read frees the slot for the new byte
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_rx_valid <= 1'b0;
      r_rx_byte  <= '0;
    end else if (rx_valid_i) begin
      if (!r_rx_valid || w_rx_pop) begin
        r_rx_valid <= 1'b1;
        r_rx_byte  <= rx_data_i;
      end
    end else if (w_rx_pop) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign wb_ack_o   = r_ack;
  assign wb_err_o   = r_err;
  assign wb_dat_o   = r_dat;
  assign int_o      = r_int;
  assign rx_ready_o = r_rx_ready;
  assign tx_valid_o = ~w_tx_empty;

endmodule : soc_uart_wb_slave
